// File: rtl/pim_chunk_engine_pkg.sv
// Shared chunk geometry, engine state encoding and MAC cycle budget
// used by the chunk engines, the controller and the benches.
package types;

    localparam int CHUNK_SIZE     = 4;
    localparam int WIDTH          = 16;
    localparam int PIM_MAC_CYCLES = CHUNK_SIZE ** 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } pim_eng_state_t;

endpackage

// File: rtl/pim_chunk_engine_mac.sv
// Single multiply-accumulate step: sum = acc + a*b, all modulo 2^W.
// Kept standalone so a pipelined version can replace it without FSM changes.
module pim_mac #(
    parameter int W = types::WIDTH
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [W-1:0] acc_i,
    output logic [W-1:0] sum_o
);

    // Context width is W, so the product and the sum both wrap at 2^W.
    assign sum_o = acc_i + a_i * b_i;

endmodule

// File: rtl/pim_chunk_engine.sv
// Chunk-local C = A x B engine: latches two NxN operand chunks on a valid
// pulse, then walks i/j/k issuing one multiply-accumulate per clock.
module pim_chunk_engine
    import types::*;
#(
    parameter int ID = 0,
    parameter int N  = types::CHUNK_SIZE,
    parameter int W  = types::WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               valid,
    input  logic [N*N*W-1:0]   matrixA,
    input  logic [N*N*W-1:0]   matrixB,
    output logic [N*N*W-1:0]   result,
    output logic               result_valid,
    output logic               busy,
    output logic [1:0]         dbg_state_o
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    // Handshake: valid is a one-cycle request sampled only in IDLE or DONE;
    // operands are taken on that same edge. result_valid is a level that
    // stays high in DONE until the next accepted request.

    pim_eng_state_t     state_q, state_d;
    logic [N*N*W-1:0]   a_q, a_d;
    logic [N*N*W-1:0]   b_q, b_d;
    logic [N*N*W-1:0]   res_q, res_d;
    logic [IW-1:0]      i_q, i_d;
    logic [IW-1:0]      j_q, j_d;
    logic [IW-1:0]      k_q, k_d;
    logic [W-1:0]       acc_q, acc_d;

    logic [W-1:0]       a_sel;
    logic [W-1:0]       b_sel;
    logic [W-1:0]       mac_sum;

    always_comb begin
        a_sel = a_q[(int'(i_q) * N + int'(k_q)) * W +: W];
        b_sel = b_q[(int'(k_q) * N + int'(j_q)) * W +: W];
    end

    pim_mac #(
        .W (W)
    ) u_mac (
        .a_i   (a_sel),
        .b_i   (b_sel),
        .acc_i (acc_q),
        .sum_o (mac_sum)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        acc_d   = acc_q;

        case (state_q)
            IDLE, DONE: begin
                if (valid) begin
                    a_d     = matrixA;
                    b_d     = matrixB;
                    res_d   = '0;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                    acc_d   = '0;
                    state_d = COMPUTE;
                end
            end
            COMPUTE: begin
                if (k_q != LAST) begin
                    acc_d = mac_sum;
                    k_d   = k_q + 1'b1;
                end else begin
                    // Last k of this dot product: commit C[i][j] and move on.
                    res_d[(int'(i_q) * N + int'(j_q)) * W +: W] = mac_sum;
                    acc_d = '0;
                    k_d   = '0;
                    if (j_q == LAST) begin
                        j_d = '0;
                        if (i_q == LAST) begin
                            i_d     = '0;
                            state_d = DONE;
                        end else begin
                            i_d = i_q + 1'b1;
                        end
                    end else begin
                        j_d = j_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
        end
    end

    // Outputs decode registered state only, so nothing combinational reaches them.
    assign result       = res_q;
    assign result_valid = (state_q == DONE);
    assign busy         = (state_q == COMPUTE);
    assign dbg_state_o  = state_q;

    a_busy_done_exclusive: assert property (
        @(posedge clk) disable iff (!rst) !(busy && result_valid)
    ) else $error("pim_chunk_engine[%0d]: busy and result_valid high together", ID);

endmodule

// File: tb/tb_pim_chunk_engine.sv
// Directed bench for pim_chunk_engine: expected product chunks are queued
// when a request is driven and checked element by element at completion.
module tb_pim_chunk_engine;
    import types::*;

    localparam int N  = CHUNK_SIZE;
    localparam int W  = WIDTH;
    localparam int NE = N * N;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            valid = 1'b0;
    logic [NE*W-1:0] matrixA = '0;
    logic [NE*W-1:0] matrixB = '0;
    logic [NE*W-1:0] result;
    logic            result_valid;
    logic            busy;
    logic [1:0]      dbg_state;

    logic [W-1:0]    exp_q[$];
    logic [W-1:0]    op_a[NE];
    logic [W-1:0]    op_b[NE];
    int              n_cmp = 0;
    int              n_err = 0;

    pim_chunk_engine #(
        .ID (0),
        .N  (N),
        .W  (W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .valid        (valid),
        .matrixA      (matrixA),
        .matrixB      (matrixB),
        .result       (result),
        .result_valid (result_valid),
        .busy         (busy),
        .dbg_state_o  (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rand_ops();
        for (int e = 0; e < NE; e++) begin
            op_a[e] = W'($urandom_range(0, 16'hffff));
            op_b[e] = W'($urandom_range(0, 16'hffff));
        end
    endtask

    task automatic push_model();
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                logic [W-1:0] s;
                logic [W-1:0] p;
                s = '0;
                for (int k = 0; k < N; k++) begin
                    p = op_a[r*N+k] * op_b[k*N+c];
                    s = s + p;
                end
                exp_q.push_back(s);
            end
        end
    endtask

    // Returns at the falling edge right after the capture edge.
    task automatic drive_start();
        @(negedge clk);
        valid = 1'b1;
        for (int e = 0; e < NE; e++) begin
            matrixA[e*W +: W] = op_a[e];
            matrixB[e*W +: W] = op_b[e];
        end
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic scramble_inputs();
        for (int e = 0; e < NE; e++) begin
            matrixA[e*W +: W] = W'($urandom_range(0, 16'hffff));
            matrixB[e*W +: W] = W'($urandom_range(0, 16'hffff));
        end
    endtask

    task automatic check_result_zero(input string tag);
        for (int e = 0; e < NE; e++)
            check($sformatf("%s elem%0d", tag, e), 32'(result[e*W +: W]), 32'd0);
    endtask

    task automatic wait_done(input string tag, input int pulse_at, input bit scramble);
        int n;
        int busy_cnt;
        n = 0;
        busy_cnt = 0;
        while (!result_valid && n < 4 * PIM_MAC_CYCLES) begin
            if (busy) busy_cnt++;
            if (scramble && n == 1) scramble_inputs();
            if (n == pulse_at) begin
                valid = 1'b1;
                scramble_inputs();
            end else begin
                valid = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        valid = 1'b0;
        check({tag, " latency"}, 32'(n), 32'(PIM_MAC_CYCLES));
        check({tag, " busy_cycles"}, 32'(busy_cnt), 32'(PIM_MAC_CYCLES));
        check({tag, " busy_low"}, 32'(busy), 32'd0);
        check({tag, " state"}, 32'(dbg_state), 32'(DONE));
        check({tag, " queue_depth"}, 32'(exp_q.size()), 32'(NE));
        for (int e = 0; e < NE; e++) begin
            if (exp_q.size() > 0)
                check($sformatf("%s elem%0d", tag, e), 32'(result[e*W +: W]), 32'(exp_q.pop_front()));
        end
    endtask

    initial begin
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("reset result_valid", 32'(result_valid), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset state", 32'(dbg_state), 32'(IDLE));
        check_result_zero("reset");
        rst = 1'b1;
        @(negedge clk);

        // Identity times 1..16 returns B unchanged.
        for (int e = 0; e < NE; e++) begin
            op_a[e] = ((e / N) == (e % N)) ? W'(1) : W'(0);
            op_b[e] = W'(e + 1);
            exp_q.push_back(W'(e + 1));
        end
        drive_start();
        wait_done("ident", -1, 1'b0);

        // A[e]=e times all-ones: every column holds the row sum; operands scrambled after capture.
        for (int e = 0; e < NE; e++) begin
            op_a[e] = W'(e);
            op_b[e] = W'(1);
            exp_q.push_back(W'(16 * (e / N) + 6));
        end
        drive_start();
        wait_done("known", -1, 1'b1);

        // 0x100 * 0x100 = 0x10000 truncates to zero.
        for (int e = 0; e < NE; e++) begin
            op_a[e] = '0;
            op_b[e] = '0;
            exp_q.push_back('0);
        end
        op_a[0] = 16'h0100;
        op_a[1] = 16'h0100;
        op_b[0] = 16'h0100;
        op_b[4] = 16'h0100;
        drive_start();
        wait_done("wrap", -1, 1'b0);

        // A second valid mid-computation must be ignored.
        rand_ops();
        push_model();
        drive_start();
        wait_done("pulse", 10, 1'b0);

        // Asynchronous reset between edges, 30 cycles into a computation.
        rand_ops();
        drive_start();
        repeat (30) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("async_rst result_valid", 32'(result_valid), 32'd0);
        check("async_rst busy", 32'(busy), 32'd0);
        check("async_rst state", 32'(dbg_state), 32'(IDLE));
        check_result_zero("async_rst");
        @(negedge clk);
        rst = 1'b1;
        rand_ops();
        push_model();
        drive_start();
        wait_done("post_rst", -1, 1'b0);

        // Hold DONE for five cycles, then restart with new operands.
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("hold%0d result_valid", c), 32'(result_valid), 32'd1);
        end
        rand_ops();
        push_model();
        drive_start();
        check("restart result_valid", 32'(result_valid), 32'd0);
        check("restart busy", 32'(busy), 32'd1);
        check_result_zero("restart");
        wait_done("restart", -1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pim_chunk_engine.md
Name: pim_chunk_engine

Overview:
Responder side of the controller-to-PIM chunk interface. The controller drives a one-cycle `valid` together with two CHUNK_SIZE x CHUNK_SIZE row-major operand chunks. This block latches the chunks and computes their chunk-local product C = A x B with one multiply-accumulate per cycle. It then presents `result` with a level `result_valid` that the controller ANDs across all four engines.

Parameters:
ID, 0, engine index; no functional effect, used only for debug/assertion messages
N, types::CHUNK_SIZE (4), chunk dimension
W, types::WIDTH (16), element and accumulator width in bits

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
valid  in  1  start request; operands qualified in the same cycle
matrixA  in  W x N*N  operand A chunk, row-major, element [r*N+c]
matrixB  in  W x N*N  operand B chunk, row-major
result  out  W x N*N  product chunk C, row-major
result_valid  out  1  level; high while `result` holds a completed product
busy  out  1  high while computing

Behaviour:
- Reset (rst low, asynchronous): state=IDLE; i, j, k, acc = 0; all result elements = 0; result_valid=0; busy=0; operand registers = 0. Effective immediately, including mid-computation; the computation in progress is discarded and never resumed.
- States:
  - IDLE: waiting for a request.
  - COMPUTE: performing multiply-accumulates.
  - DONE: result held, result_valid=1.
- IDLE or DONE with valid=1 at a rising edge (capture edge E0):
  - copy matrixA/matrixB into internal registers;
  - clear all result elements to 0; i=j=k=0; acc=0;
  - state goes to COMPUTE; busy=1; result_valid=0.
  - After E0, inputs are don't-care until the next request.
- COMPUTE, each edge:
  - p = A[i*N+k] * B[k*N+j], truncated to W bits;
  - if k<N-1: acc = acc + p (mod 2^W); k++;
  - if k==N-1: result[i*N+j] = acc + p (mod 2^W); acc=0; k=0; advance j, and when j wraps to 0 advance i.
  - On the edge that writes element (N-1,N-1): state goes to DONE; busy=0; result_valid=1.
- Latency: result_valid rises on the N^3-th rising edge after E0 (64 for N=4). Engines started together finish on the same edge.
- valid during COMPUTE: ignored; no restart, no error flag.
- DONE: result and result_valid are held indefinitely. valid=1 restarts per the capture rule, and result_valid drops on that same edge.
- Arithmetic: unsigned; products and sums wrap modulo 2^W; no saturation, no overflow flag.
- result elements not yet written during COMPUTE read 0. result is only meaningful while result_valid=1.
- No combinational path from inputs to outputs; all outputs are registered.

Decomposition:
- Shared package `types`:
  - CHUNK_SIZE and WIDTH (existing);
  - new enum pim_eng_state_t {IDLE, COMPUTE, DONE};
  - new constant PIM_MAC_CYCLES = CHUNK_SIZE**3, used by the controller and benches for timeout checks.
- One sub-module: pim_mac. It is a combinational W-bit multiply plus add-to-accumulator with modulo-2^W truncation, kept separate so it can later be pipelined without touching the FSM.
- The FSM, index counters and operand/result registers stay in pim_chunk_engine.

Test Plan:
- Identity test: A = identity, B[e] = e+1 for e=0..15, single-cycle valid.
  - Required: result[e] = e+1 for all e.
  - Required: result_valid rises exactly 64 edges after capture, and busy is high for exactly those 64 cycles.
- Known product: A[e]=e, B[e]=1.
  - Required: result[r*4+c] = 4r*4+6 (0+1+2+3 offset by row), i.e. row sums 6, 22, 38, 54 repeated across each row.
  - Operands are changed to random values one cycle after capture; the result must not change.
- Wrap-around, W=16: A[0]=A[1]=0x0100, B[0]=B[4]=0x0100, all other elements 0.
  - Required: result[0] = 0x0000 (products of 0x10000 truncate); all other elements 0.
- valid pulsed again at cycle 10 of COMPUTE with different operands.
  - Required: ignored; the original result appears at edge 64; busy never deasserts early.
- rst asserted low asynchronously (between edges) at cycle 30, then released.
  - Required: result_valid=0, busy=0 and result all 0 immediately.
  - Required: a fresh valid then completes correctly in 64 cycles.
- Restart from DONE: hold DONE for 5 cycles, then apply valid with new operands.
  - Required: result_valid falls on the capture edge and result reads 0.
  - Required: the new product and result_valid appear 64 edges later.
